// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl_pkg
//  Description : Shared constants for the load/store unit. Holds the ALU
//                operation codes used by the pipeline, the LSU state
//                encodings, the access-size constants and a small decoder
//                that turns an alucode into access attributes.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_ctrl_pkg;

  // ALU operation codes shared with the pipeline
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

  // LSU state encodings
  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_ACC0 = 2'd1;
  localparam logic [1:0] LSU_ACC1 = 2'd2;
  localparam logic [1:0] LSU_DONE = 2'd3;

  // Access sizes in bytes
  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  typedef struct packed {
    logic       ok;     // alucode is a supported load/store
    logic       store;  // 1 = store, 0 = load
    logic       sext;   // sign-extend load result
    logic [2:0] size;   // access size in bytes
  } lsu_op_t;

  function automatic lsu_op_t decode_op(input logic [5:0] code);
    lsu_op_t op;
    op = '0;
    case (code)
      ALU_LB:  op = '{1'b1, 1'b0, 1'b1, SIZE_B};
      ALU_LBU: op = '{1'b1, 1'b0, 1'b0, SIZE_B};
      ALU_LH:  op = '{1'b1, 1'b0, 1'b1, SIZE_H};
      ALU_LHU: op = '{1'b1, 1'b0, 1'b0, SIZE_H};
      ALU_LW:  op = '{1'b1, 1'b0, 1'b0, SIZE_W};
      ALU_SB:  op = '{1'b1, 1'b1, 1'b0, SIZE_B};
      ALU_SH:  op = '{1'b1, 1'b1, 1'b0, SIZE_H};
      ALU_SW:  op = '{1'b1, 1'b1, 1'b0, SIZE_W};
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational byte-lane steering for the LSU. Produces the
//                low/high word write strobes and write data for an access at
//                byte offset 'off', and merges/extends load data from the
//                captured low/high words.
//  Ports       : off      in  2   byte offset within the first word
//                size     in  3   access size in bytes (1/2/4)
//                sext     in  1   sign-extend the load result
//                wdata    in  32  right-justified store data
//                rd_lo    in  32  word read at the first address
//                rd_hi    in  32  word read at the next address (0 if none)
//                we_lo    out 4   strobes for the first word
//                we_hi    out 4   strobes for the second word
//                wd_lo    out 32  write data for the first word
//                wd_hi    out 32  write data for the second word
//                rdata    out 32  extended load result
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_lane_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [3:0]  we_lo,
  output logic [3:0]  we_hi,
  output logic [31:0] wd_lo,
  output logic [31:0] wd_hi,
  output logic [31:0] rdata
);

  logic [3:0]  w_mask;
  logic [7:0]  w_strb;
  logic [63:0] w_wide;
  logic [63:0] w_merged;
  logic [31:0] w_low;

  always_comb begin
    case (size)
      SIZE_B:  w_mask = 4'h1;
      SIZE_H:  w_mask = 4'h3;
      default: w_mask = 4'hF;
    endcase
    // Shifting into an 8-bit/64-bit space lets the bytes that spill past
    // the word boundary land naturally in the upper (second-word) half.
    w_strb   = {4'h0, w_mask} << off;
    w_wide   = {32'h0, wdata} << {off, 3'b000};
    w_merged = {rd_hi, rd_lo} >> {off, 3'b000};
    w_low    = w_merged[31:0];

    we_lo = w_strb[3:0];
    we_hi = w_strb[7:4];
    wd_lo = w_wide[31:0];
    wd_hi = w_wide[63:32];

    case (size)
      SIZE_B:  rdata = sext ? {{24{w_low[7]}},  w_low[7:0]}  : {24'h0, w_low[7:0]};
      SIZE_H:  rdata = sext ? {{16{w_low[15]}}, w_low[15:0]} : {16'h0, w_low[15:0]};
      default: rdata = w_low;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store initiator between the MEM stage and data_mem.
//                Issues only word-aligned accesses, splitting word-crossing
//                accesses into two transactions, and returns extended load
//                data as a one-cycle response pulse.
//  Ports       : clk, rst                 clock / sync active-high reset
//                req_valid/ready          request handshake (ready in IDLE)
//                req_alucode/addr/wdata   request attributes
//                resp_valid/rdata/err     one-cycle completion pulse
//                mem_r_addr/w_addr        word-aligned memory addresses
//                mem_w_data/we            lane-steered write data / strobes
//                mem_alucode              constant ALU_LW
//                mem_is_store             high while any strobe is set
//                mem_r_data               word returned by data_mem
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_alucode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [31:0]       mem_w_data,
  output logic [3:0]        mem_we,
  output logic [5:0]        mem_alucode,
  output logic              mem_is_store,
  input  logic [31:0]       mem_r_data
);

  logic [1:0]        r_state;
  logic              r_store;
  logic              r_sext;
  logic              r_err;
  logic [2:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_lo;
  logic [31:0]       r_hi;

  lsu_op_t           w_op;
  logic              w_cross;
  logic [ADDR_W-1:0] w_word_addr;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [3:0]        w_we_lo;
  logic [3:0]        w_we_hi;
  logic [31:0]       w_wd_lo;
  logic [31:0]       w_wd_hi;
  logic [31:0]       w_rdata;

  assign w_op        = decode_op(req_alucode);
  assign w_cross     = ({2'b00, r_addr[1:0]} + {1'b0, r_size}) > 4'd4;
  assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

  lsu_lane_align u_align (
    .off   (r_addr[1:0]),
    .size  (r_size),
    .sext  (r_sext),
    .wdata (r_wdata),
    .rd_lo (r_lo),
    .rd_hi (r_hi),
    .we_lo (w_we_lo),
    .we_hi (w_we_hi),
    .wd_lo (w_wd_lo),
    .wd_hi (w_wd_hi),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LSU_IDLE;
      r_store <= 1'b0;
      r_sext  <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_lo    <= 32'h0;
      r_hi    <= 32'h0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_store <= w_op.store;
            r_sext  <= w_op.sext;
            r_size  <= w_op.size;
            r_err   <= ~w_op.ok;
            // hi stays 0 unless a second word is actually read
            r_hi    <= 32'h0;
            r_state <= w_op.ok ? LSU_ACC0 : LSU_DONE;
          end
        end
        LSU_ACC0: begin
          if (!r_store) r_lo <= mem_r_data;
          r_state <= w_cross ? LSU_ACC1 : LSU_DONE;
        end
        LSU_ACC1: begin
          if (!r_store) r_hi <= mem_r_data;
          r_state <= LSU_DONE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (r_state == LSU_IDLE);
    resp_valid = (r_state == LSU_DONE);
    resp_err   = (r_state == LSU_DONE) && r_err;
    resp_rdata = 32'h0;
    if ((r_state == LSU_DONE) && !r_err && !r_store) resp_rdata = w_rdata;

    w_acc_addr = '0;
    mem_we     = 4'h0;
    mem_w_data = 32'h0;
    case (r_state)
      LSU_ACC0: begin
        w_acc_addr = w_word_addr;
        if (r_store) begin
          mem_we     = w_we_lo;
          mem_w_data = w_wd_lo;
        end
      end
      LSU_ACC1: begin
        // Natural modulo-2^ADDR_W wrap of the second word address
        w_acc_addr = w_word_addr + ADDR_W'(4);
        if (r_store) begin
          mem_we     = w_we_hi;
          mem_w_data = w_wd_hi;
        end
      end
      default: ;
    endcase
    mem_r_addr = w_acc_addr;
    mem_w_addr = w_acc_addr;
  end

  assign mem_is_store = |mem_we;
  assign mem_alucode  = ALU_LW;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Bench for lsu_ctrl paired with a byte-addressed data_mem
//                model. A byte-level reference memory predicts every
//                response; directed vectors pin the model with literals.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_alucode = 6'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_we;
  logic [5:0]  mem_alucode;
  logic        mem_is_store;
  logic [31:0] mem_r_data = 32'h0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_alucode  (req_alucode),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_r_addr   (mem_r_addr),
    .mem_w_addr   (mem_w_addr),
    .mem_w_data   (mem_w_data),
    .mem_we       (mem_we),
    .mem_alucode  (mem_alucode),
    .mem_is_store (mem_is_store),
    .mem_r_data   (mem_r_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- data_mem (acts on falling edge) and reference -------
  logic [7:0] dm [logic [31:0]];
  logic [7:0] rm [logic [31:0]];
  logic [3:0]  we_log [$];
  logic [31:0] wa_log [$];

  function automatic logic [7:0] dm_byte(input logic [31:0] a);
    return dm.exists(a) ? dm[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rm_byte(input logic [31:0] a);
    return rm.exists(a) ? rm[a] : 8'h00;
  endfunction

  function automatic logic [31:0] dm_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = dm_byte(a + 32'(i));
    return w;
  endfunction

  always @(negedge clk) begin
    if (mem_we != 4'h0) begin
      we_log.push_back(mem_we);
      wa_log.push_back(mem_w_addr);
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) dm[mem_w_addr + 32'(i)] = mem_w_data[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) mem_r_data[8*i +: 8] = dm_byte(mem_r_addr + 32'(i));
  end

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      dm[a + 32'(i)] = w[8*i +: 8];
      rm[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  task automatic poke_byte(input logic [31:0] a, input logic [7:0] b);
    dm[a] = b;
    rm[a] = b;
  endtask

  // ---------------- behavioural model -----------------------------------
  function automatic int op_size(input logic [5:0] c);
    if (c == ALU_LB || c == ALU_LBU || c == ALU_SB) return 1;
    if (c == ALU_LH || c == ALU_LHU || c == ALU_SH) return 2;
    if (c == ALU_LW || c == ALU_SW) return 4;
    return 0;
  endfunction

  function automatic bit op_store(input logic [5:0] c);
    return (c == ALU_SB || c == ALU_SH || c == ALU_SW);
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] c, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = op_size(c);
    v  = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rm_byte(a + 32'(i));
    if (c == ALU_LB && v[7])  v = v | 32'hFFFFFF00;
    if (c == ALU_LH && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  bit          pend = 1'b0;
  int          cyc = 0;
  int          exp_done = 0;
  int          acc_cyc = 0;
  bit          m_store = 1'b0;
  bit          m_err = 1'b0;
  int          m_size = 0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  int          resp_count = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (cyc - 1 == exp_done) begin
        if (m_store)
          for (int i = 0; i < m_size; i++) rm[m_addr + 32'(i)] = m_wdata[8*i +: 8];
        pend = 1'b0;
      end
    end else if (req_valid) begin
      acc_cyc = cyc - 1;
      m_size  = op_size(req_alucode);
      m_addr  = req_addr;
      m_wdata = req_wdata;
      m_err   = (m_size == 0);
      m_store = !m_err && op_store(req_alucode);
      if (m_err) exp_done = acc_cyc + 1;
      else exp_done = acc_cyc + ((int'(req_addr[1:0]) + m_size > 4) ? 3 : 2);
      m_rdata = (m_err || m_store) ? 32'h0 : model_load(req_alucode, req_addr);
      pend = 1'b1;
    end
    #1;
    check("cyc_resp_valid", {31'h0, resp_valid}, {31'h0, pend && (cyc == exp_done)});
    check("cyc_req_ready", {31'h0, req_ready}, {31'h0, !pend});
    if (!(pend && m_store && cyc < exp_done))
      check("cyc_mem_we_idle", {28'h0, mem_we}, 32'h0);
    check("cyc_addr_align", {28'h0, mem_r_addr[1:0], mem_w_addr[1:0]}, 32'h0);
    check("cyc_is_store", {31'h0, mem_is_store}, {31'h0, mem_we != 4'h0});
    if (pend && cyc == exp_done) begin
      check("cyc_resp_rdata", resp_rdata, m_rdata);
      check("cyc_resp_err", {31'h0, resp_err}, {31'h0, m_err});
    end
    if (resp_valid) begin
      resp_count++;
      last_rdata = resp_rdata;
      last_err   = resp_err;
      last_lat   = cyc - acc_cyc;
    end
  end

  // ---------------- stimulus helpers ------------------------------------
  task automatic issue(input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] w, input bit hold);
    int guard;
    @(negedge clk);
    req_alucode = c;
    req_addr    = a;
    req_wdata   = w;
    req_valid   = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    if (hold) begin
      guard = 0;
      while (!req_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while ((pend || !req_ready) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 30) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got busy required idle", name);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int rc0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready",  {31'h0, req_ready},  32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err",   {31'h0, resp_err},   32'h0);
    check("rst_mem_we",     {28'h0, mem_we},     32'h0);
    check("rst_mem_addr",   mem_r_addr | mem_w_addr, 32'h0);
    check("rst_mem_w_data", mem_w_data, 32'h0);
    check("mem_alucode",    {26'h0, mem_alucode}, {26'h0, ALU_LW});
    rst = 1'b0;

    // 1: plain word load
    poke_word(32'h100, 32'hDEADBEEF);
    we_log.delete(); wa_log.delete();
    issue(ALU_LW, 32'h100, 32'h0, 1'b0);
    wait_idle("t1");
    check("t1_rdata", last_rdata, 32'hDEADBEEF);
    check("t1_latency", 32'(last_lat), 32'd2);
    check("t1_no_writes", 32'(we_log.size()), 32'd0);

    // 2: byte/half loads with extension
    poke_word(32'h100, 32'h80FF7F01);
    issue(ALU_LB, 32'h103, 32'h0, 1'b0);  wait_idle("t2a");
    check("t2_lb", last_rdata, 32'hFFFFFF80);
    issue(ALU_LBU, 32'h103, 32'h0, 1'b0); wait_idle("t2b");
    check("t2_lbu", last_rdata, 32'h00000080);
    issue(ALU_LH, 32'h102, 32'h0, 1'b0);  wait_idle("t2c");
    check("t2_lh", last_rdata, 32'hFFFF80FF);
    issue(ALU_LHU, 32'h102, 32'h0, 1'b0); wait_idle("t2d");
    check("t2_lhu", last_rdata, 32'h000080FF);
    issue(ALU_LB, 32'h101, 32'h0, 1'b0);  wait_idle("t2e");
    check("t2_lb_pos", last_rdata, 32'h0000007F);

    // 3: crossing word store
    poke_word(32'h204, 32'hAAAAAAAA);
    poke_word(32'h208, 32'hAAAAAAAA);
    we_log.delete(); wa_log.delete();
    issue(ALU_SW, 32'h205, 32'h11223344, 1'b0);
    wait_idle("t3");
    check("t3_latency", 32'(last_lat), 32'd3);
    check("t3_rdata", last_rdata, 32'h0);
    check("t3_n_writes", 32'(we_log.size()), 32'd2);
    if (we_log.size() == 2) begin
      check("t3_we0", {28'h0, we_log[0]}, 32'h0000000E);
      check("t3_wa0", wa_log[0], 32'h204);
      check("t3_we1", {28'h0, we_log[1]}, 32'h00000001);
      check("t3_wa1", wa_log[1], 32'h208);
    end
    check("t3_word204", dm_word(32'h204), 32'h223344AA);
    check("t3_word208", dm_word(32'h208), 32'hAAAAAA11);
    issue(ALU_LW, 32'h204, 32'h0, 1'b0); wait_idle("t3r");
    check("t3_readback", last_rdata, 32'h223344AA);

    // 4: half load wrapping the top of the address space
    poke_byte(32'hFFFFFFFF, 8'h34);
    poke_byte(32'h00000000, 8'h92);
    issue(ALU_LH, 32'hFFFFFFFF, 32'h0, 1'b0);
    wait_idle("t4");
    check("t4_wrap_lh", last_rdata, 32'hFFFF9234);
    check("t4_latency", 32'(last_lat), 32'd3);

    // 5: reset during ACC0 of a crossing SH
    poke_word(32'h300, 32'h55555555);
    poke_word(32'h304, 32'h55555555);
    rc0 = resp_count;
    @(negedge clk);
    req_alucode = ALU_SH; req_addr = 32'h303; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready_after_rst", {31'h0, req_ready}, 32'h1);
    repeat (5) @(negedge clk);
    check("t5_no_resp", 32'(resp_count - rc0), 32'd0);
    check("t5_word304", dm_word(32'h304), 32'h55555555);

    // 6: unsupported alucode, request held while busy
    we_log.delete(); wa_log.delete();
    rc0 = resp_count;
    issue(ALU_ADD, 32'h100, 32'h12345678, 1'b1);
    wait_idle("t6");
    check("t6_one_resp", 32'(resp_count - rc0), 32'd1);
    check("t6_err", {31'h0, last_err}, 32'h1);
    check("t6_rdata", last_rdata, 32'h0);
    check("t6_no_writes", 32'(we_log.size()), 32'd0);

    // crossing load held across all busy cycles: one accept only
    poke_word(32'h104, 32'h44332211);
    rc0 = resp_count;
    issue(ALU_LW, 32'h102, 32'h0, 1'b1);
    wait_idle("t6b");
    check("t6b_one_resp", 32'(resp_count - rc0), 32'd1);
    check("t6b_rdata", last_rdata, 32'h221180FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
